aexm_icache: RTL and testbench
==============================

Name: aexm_icache

Overview:
- Direct-mapped instruction cache that answers the fetch address driven by the branch/PC unit (aexm_icache_precycle_addr) and returns the instruction word one cycle later.
- On a miss it asserts aexm_icache_busy so the core holds x_en low. It fills a 4-word line from the memory port, replays the lookup, then releases the core.
- Sits between the core fetch stage and the instruction memory bus.

Parameters:
IW, 24, instruction address width in bytes; addresses carried as [IW-1:2].
LW, 2, log2 words per line (4 words).
IDX, 6, log2 number of lines (64); tag width TW = IW-2-LW-IDX (14 at defaults).

Ports:
gclk  in  1  core clock
grst  in  1  reset, synchronous, active-high
x_en  in  1  core pipeline advance; fetch address accepted only when x_en=1 and busy=0
aexm_icache_precycle_addr  in  IW-2  next fetch word address from the PC unit
aexm_icache_datai  out  32  instruction word for the captured address
aexm_icache_busy  out  1  core must hold x_en low while 1
icache_flush  in  1  single-cycle pulse; invalidate all lines
mem_req  out  1  line-fill request, held until last beat acked
mem_addr  out  IW-2  word address of current fill beat
mem_ack  in  1  beat accepted; mem_data valid this cycle
mem_data  in  32  fill data

Behaviour:
- Address split: word offset [LW-1:0], index [LW+IDX-1:LW], tag [IW-3:LW+IDX] of the word address.
- Arrays:
  - valid bit per line.
  - TW-bit tag per line.
  - data RAM of 2^(IDX+LW) words.
  - All reads synchronous, addressed by precycle_addr in LOOKUP, by rADDR in REPLAY.
- Capture: at posedge with x_en=1 and busy=0, rADDR <= precycle_addr and rLKV <= 1. x_en while busy=1 is ignored.
- Latency: data for an address accepted at edge N is on datai after edge N, combinational from the RAM output register. Back-to-back hits sustain one word per cycle.
- Hit = rLKV & valid[idx] & (tag==rADDR tag). In LOOKUP, busy = rLKV & !hit (combinational). Core stalls in that same cycle.
- States:
  - SWEEP: clear valid[cnt], cnt++. After 2^IDX cycles go to LOOKUP, or to REPLAY if entered from FILL. busy=1.
  - LOOKUP: on miss go to FILL with beat=0. On icache_flush (no miss pending) go to SWEEP. Flush and miss in the same cycle: FILL first, flush held pending.
  - FILL:
    - mem_req=1; mem_addr = {rADDR tag, rADDR idx, beat}.
    - Each mem_ack writes mem_data to data[idx,beat] and increments beat.
    - Ack of beat 2^LW-1 writes tag and sets valid in the same edge, drops mem_req next cycle, then goes to SWEEP if flush pending, else to REPLAY.
    - mem_ack gaps of any length are allowed. mem_ack while mem_req=0 is ignored.
  - REPLAY: re-read arrays at rADDR for 1 cycle, busy=1, then LOOKUP. The result is a hit, or a refill if a flush intervened.
- Flush pending: set by icache_flush in any state other than LOOKUP-idle, cleared on entering SWEEP. A flush during SWEEP restarts cnt at 0.
- Reset (including mid-fill):
  - state=SWEEP, cnt=0, rLKV=0, rADDR=0, flush pending=0.
  - mem_req=0, mem_addr=0, datai=0, busy=1.
  - An in-flight fill is abandoned; acks after reset are ignored.
- After the reset sweep with rLKV=0: busy=0, datai=0, no miss until the first capture.
- Beat counter wraps from 2^LW-1 to 0. cnt is IDX bits and wraps to 0 on exit.

Test Plan:
- Reset: assert grst 1 cycle -> busy=1 for exactly 64 cycles, mem_req=0 throughout, datai=0; then busy=0.
- Cold miss:
  - Stimulus: capture addr 0x100 (byte 0x400); mem_ack every cycle with data 0xA0..0xA3.
  - Required: mem_addr sequence 0x100,0x101,0x102,0x103; mem_req low after 4th ack; 1 REPLAY cycle; then datai=0xA0, busy=0.
- Hits: capture 0x101,0x102,0x103 consecutively -> datai 0xA1,0xA2,0xA3 on successive cycles, busy stays 0, mem_req 0.
- Conflict and gapped acks:
  - Stimulus: capture 0x200 (same idx 0, tag 2); acks with 2-cycle gaps.
  - Required: refill with mem_addr 0x200..0x203; afterwards 0x100 misses again.
- Flush during fill: pulse icache_flush on beat 1 -> fill completes, 64-cycle SWEEP, REPLAY misses, line refetched (mem_req reasserted with mem_addr 0x100).
- Reset mid-fill: assert grst after beat 2 ack -> mem_req=0 next cycle, later acks ignored, 64-cycle sweep, address 0x100 misses afterwards.

Source files
------------

// File: rtl/aexm_icache.sv
// Direct-mapped instruction cache for the aexm fetch stage.
// A fetch address captured on one edge returns its word on datai after that
// edge. A miss raises busy, fills the whole line from the memory port, re-reads
// the arrays once (REPLAY) and then releases the core.
//
// Handshakes:
//   core side  : a fetch address transfers on an edge where x_en=1 and busy=0.
//                x_en while busy=1 has no effect.
//   memory side: mem_req rises with the first beat address on mem_addr and
//                stays high until the last beat is accepted. A beat transfers
//                on every edge with mem_req=1 and mem_ack=1, and mem_addr
//                advances on that same edge. mem_ack while mem_req=0 is ignored.
module aexm_icache #(
  parameter int IW  = 24,
  parameter int LW  = 2,
  parameter int IDX = 6
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          x_en,
  input  logic [IW-3:0] aexm_icache_precycle_addr,
  output logic [31:0]   aexm_icache_datai,
  output logic          aexm_icache_busy,
  input  logic          icache_flush,
  output logic          mem_req,
  output logic [IW-3:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_data,
  output logic [1:0]    dbgState
);

  localparam int TW = IW - 2 - LW - IDX;
  localparam int NL = 1 << IDX;
  localparam int NW = 1 << (IDX + LW);

  typedef enum logic [1:0] {
    SWEEP  = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    REPLAY = 2'd3
  } state_t;

  state_t          rState;
  logic [IW-3:0]   rADDR;
  logic            rLKV;
  logic [LW-1:0]   rBeat;
  logic [IDX-1:0]  rCnt;
  logic            rFlushPend;
  logic            rSweepToReplay;
  logic            rMemReq;
  logic [IW-3:0]   rMemAddr;

  // Line state and storage.
  logic [NL-1:0]   rValid;
  logic [TW-1:0]   tagRam  [NL];
  logic [31:0]     dataRam [NW];

  // Registered array outputs.
  logic            rValidQ;
  logic [TW-1:0]   rTagQ;
  logic [31:0]     rData;

  logic              hit;
  logic              lookupMiss;
  logic              busy;
  logic              accept;
  logic              rdEn;
  logic [LW+IDX-1:0] rdAddr;
  logic [IDX-1:0]    rdIdx;
  logic [IDX-1:0]    fillIdx;
  logic              fillAck;
  logic              lastBeat;
  logic              flushReq;

  // Lookup compare, stall and array-read addressing.
  always_comb begin
    hit        = rLKV & rValidQ & (rTagQ == rADDR[IW-3:LW+IDX]);
    lookupMiss = (rState == LOOKUP) & rLKV & ~hit;
    busy       = (rState != LOOKUP) | lookupMiss;
    accept     = x_en & ~busy;
    rdEn       = accept | (rState == REPLAY);
    rdAddr     = (rState == REPLAY) ? rADDR[LW+IDX-1:0]
                                    : aexm_icache_precycle_addr[LW+IDX-1:0];
    rdIdx      = rdAddr[LW+IDX-1:LW];
    fillIdx    = rADDR[LW+IDX-1:LW];
    fillAck    = (rState == FILL) & rMemReq & mem_ack;
    lastBeat   = fillAck & (&rBeat);
    flushReq   = icache_flush | rFlushPend;
  end

  assign aexm_icache_busy  = busy;
  assign aexm_icache_datai = rData;
  assign mem_req           = rMemReq;
  assign mem_addr          = rMemAddr;
  assign dbgState          = rState;

  // Control FSM: capture register, sweep counter, fill sequencing, flush tracking.
  always_ff @(posedge gclk) begin
    if (grst) begin
      rState         <= SWEEP;
      rCnt           <= '0;
      rLKV           <= 1'b0;
      rADDR          <= '0;
      rFlushPend     <= 1'b0;
      rSweepToReplay <= 1'b0;
      rBeat          <= '0;
      rMemReq        <= 1'b0;
      rMemAddr       <= '0;
    end else begin
      if (accept) begin
        rADDR <= aexm_icache_precycle_addr;
        rLKV  <= 1'b1;
      end
      unique case (rState)
        SWEEP: begin
          // A flush arriving mid-sweep restarts the walk from line 0.
          if (icache_flush) begin
            rCnt <= '0;
          end else begin
            rCnt <= rCnt + 1'b1;
            if (&rCnt) rState <= rSweepToReplay ? REPLAY : LOOKUP;
          end
        end
        LOOKUP: begin
          // A miss wins over a flush; the flush is remembered for after the fill.
          if (lookupMiss) begin
            rState     <= FILL;
            rBeat      <= '0;
            rMemReq    <= 1'b1;
            rMemAddr   <= {rADDR[IW-3:LW], {LW{1'b0}}};
            rFlushPend <= flushReq;
          end else if (flushReq) begin
            rState         <= SWEEP;
            rCnt           <= '0;
            rFlushPend     <= 1'b0;
            rSweepToReplay <= 1'b0;
          end
        end
        FILL: begin
          if (icache_flush) rFlushPend <= 1'b1;
          if (fillAck) begin
            rBeat             <= rBeat + 1'b1;
            rMemAddr[LW-1:0]  <= rBeat + 1'b1;
            if (lastBeat) begin
              rMemReq <= 1'b0;
              if (flushReq) begin
                rState         <= SWEEP;
                rCnt           <= '0;
                rFlushPend     <= 1'b0;
                rSweepToReplay <= 1'b1;
              end else begin
                rState <= REPLAY;
              end
            end
          end
        end
        REPLAY: begin
          if (icache_flush) rFlushPend <= 1'b1;
          rState <= LOOKUP;
        end
        default: rState <= SWEEP;
      endcase
    end
  end

  // Valid bits: cleared one line per cycle while sweeping, set by the last fill beat.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      if (rState == SWEEP) rValid[rCnt] <= 1'b0;
      else if (lastBeat)   rValid[fillIdx] <= 1'b1;
    end
  end

  // Tag and data storage writes from the fill port.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      if (fillAck)  dataRam[{fillIdx, rBeat}] <= mem_data;
      if (lastBeat) tagRam[fillIdx] <= rADDR[IW-3:LW+IDX];
    end
  end

  // Synchronous array read; the output register holds between accepted reads.
  always_ff @(posedge gclk) begin
    if (grst) begin
      rValidQ <= 1'b0;
      rTagQ   <= '0;
      rData   <= '0;
    end else if (rdEn) begin
      rValidQ <= rValid[rdIdx];
      rTagQ   <= tagRam[rdIdx];
      rData   <= dataRam[rdAddr];
    end
  end

endmodule

// File: tb/tb_aexm_icache.sv
// Bench for aexm_icache: directed scenarios followed by random fetches,
// checked against a line-level cache model and a fill-address scoreboard.
module tb_aexm_icache;

  logic        gclk = 1'b0;
  logic        grst;
  logic        x_en;
  logic [21:0] precycle;
  logic [31:0] datai;
  logic        busy;
  logic        icache_flush;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_ack  = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic [1:0]  dbgState;

  aexm_icache dut (
    .gclk                      (gclk),
    .grst                      (grst),
    .x_en                      (x_en),
    .aexm_icache_precycle_addr (precycle),
    .aexm_icache_datai         (datai),
    .aexm_icache_busy          (busy),
    .icache_flush              (icache_flush),
    .mem_req                   (mem_req),
    .mem_addr                  (mem_addr),
    .mem_ack                   (mem_ack),
    .mem_data                  (mem_data),
    .dbgState                  (dbgState)
  );

  // Clock.
  always #5 gclk = ~gclk;

  int nComp = 0;
  int nFail = 0;

  // Scoreboard of fill beat addresses the cache must request, in order.
  logic [21:0] exp_q[$];

  // Backing memory image and cache model (valid/tag per line).
  logic [31:0] memImg [logic [21:0]];
  bit          mValid [64];
  logic [13:0] mTag   [64];
  logic [21:0] lastA;

  // Memory responder controls.
  int          ackGap = 0;
  int          gapCnt = 0;
  int          nAcked = 0;
  bit          forceAck = 1'b0;
  bit          ackedReal = 1'b0;
  bit          chkReqDrop = 1'b0;
  logic [21:0] respE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nComp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [21:0] a);
    if (memImg.exists(a)) return memImg[a];
    return 32'h5A00_0000 ^ ({10'd0, a} * 32'h9E37_79B1);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
  endtask

  // Predict hit/miss; on a miss queue the line's beat addresses and install it.
  task automatic predict(input logic [21:0] a, output bit hit);
    int ix;
    logic [13:0] tg;
    ix  = int'(a[7:2]);
    tg  = a[21:8];
    hit = mValid[ix] && (mTag[ix] == tg);
    if (!hit) begin
      for (int b = 0; b < 4; b++) exp_q.push_back({a[21:2], 2'(b)});
      mValid[ix] = 1'b1;
      mTag[ix]   = tg;
    end
  endtask

  // Memory responder: acks with a programmable gap, scores each beat address.
  always @(posedge gclk) begin
    #1;
    if (ackedReal) nAcked++;
    ackedReal = 1'b0;
    if (chkReqDrop) begin
      chk("req_drop", {31'd0, mem_req}, 32'd0);
      chkReqDrop = 1'b0;
    end
    if (forceAck) begin
      mem_ack  = 1'b1;
      mem_data = $urandom;
    end else if (mem_req && gapCnt >= ackGap) begin
      if (exp_q.size() > 0) respE = exp_q.pop_front();
      else                  respE = 22'h3F_FFFF;
      chk("fill_addr", {10'd0, mem_addr}, {10'd0, respE});
      mem_ack   = 1'b1;
      mem_data  = memWord(mem_addr);
      gapCnt    = 0;
      ackedReal = 1'b1;
      if (exp_q.size() == 0) chkReqDrop = 1'b1;
    end else begin
      mem_ack  = 1'b0;
      mem_data = $urandom;
      if (mem_req) gapCnt++;
      else         gapCnt = ackGap;
    end
  end

  // Count cycles until busy releases, noting any memory request on the way.
  task automatic sweepCount(output int n, output logic reqSeen);
    n = 0;
    reqSeen = 1'b0;
    while (busy && n < 400) begin
      @(posedge gclk); #2;
      n++;
      reqSeen |= mem_req;
    end
  endtask

  // One fetch: a hit returns data next cycle; a miss takes 6 + 3*gap cycles.
  task automatic fetch(input logic [21:0] a, input int gap);
    bit hit;
    int n;
    ackGap = gap;
    predict(a, hit);
    x_en = 1'b1;
    precycle = a;
    @(posedge gclk); #2;
    if (hit) begin
      chk("hit_busy", {31'd0, busy}, 32'd0);
      chk("hit_data", datai, memWord(a));
      chk("hit_req", {31'd0, mem_req}, 32'd0);
    end else begin
      chk("miss_busy", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 400) begin
        x_en = 1'($urandom_range(0, 1));
        precycle = 22'($urandom);
        @(posedge gclk); #2;
        n++;
      end
      x_en = 1'b0;
      chk("miss_cycles", n, 6 + 3 * gap);
      chk("miss_data", datai, memWord(a));
      chk("miss_fills_left", exp_q.size(), 32'd0);
    end
    lastA = a;
  endtask

  task automatic flushIdle();
    int n;
    logic rs;
    x_en = 1'b0;
    icache_flush = 1'b1;
    @(posedge gclk); #2;
    icache_flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd1);
    sweepCount(n, rs);
    chk("flush_sweep_len", n, 32'd64);
    chk("flush_no_req", {31'd0, rs}, 32'd0);
    clearModel();
  endtask

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bit h;
    bit flushed;
    logic rs;
    int ta, ia, oa;

    grst = 1'b1; x_en = 1'b0; precycle = '0; icache_flush = 1'b0;
    clearModel();
    memImg[22'h100] = 32'h0000_00A0;
    memImg[22'h101] = 32'h0000_00A1;
    memImg[22'h102] = 32'h0000_00A2;
    memImg[22'h103] = 32'h0000_00A3;

    // Reset and the initial sweep.
    repeat (2) @(posedge gclk);
    #2 grst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {10'd0, mem_addr}, 32'd0);
    chk("rst_datai", datai, 32'd0);
    sweepCount(n, rs);
    chk("rst_sweep_len", n, 32'd64);
    chk("rst_no_req", {31'd0, rs}, 32'd0);
    repeat (3) begin @(posedge gclk); #2; end
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_datai", datai, 32'd0);

    // Cold miss on 0x100, then back-to-back hits across the line.
    fetch(22'h100, 0);
    fetch(22'h101, 0);
    fetch(22'h102, 0);
    fetch(22'h103, 0);
    fetch(22'h100, 0);
    x_en = 1'b0;

    // Acks while no request is outstanding must not disturb anything.
    forceAck = 1'b1;
    repeat (3) begin @(posedge gclk); #2; end
    forceAck = 1'b0;
    @(posedge gclk); #2;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_busy", {31'd0, busy}, 32'd0);
    chk("stray_ack_data", datai, 32'h0000_00A0);
    fetch(22'h101, 0);
    x_en = 1'b0;

    // Conflict on index 0 with gapped acks.
    fetch(22'h200, 2);

    // 0x100 misses again; a flush on beat 1 forces sweep and a second fill.
    ackGap = 0;
    predict(22'h100, h);
    clearModel();
    mValid[0] = 1'b1;
    mTag[0]   = 14'h1;
    for (int b = 0; b < 4; b++) exp_q.push_back({20'h40, 2'(b)});
    base = nAcked;
    flushed = 1'b0;
    x_en = 1'b1;
    precycle = 22'h100;
    @(posedge gclk); #2;
    x_en = 1'b0;
    chk("ff_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 400) begin
      if (!flushed && nAcked == base + 1) begin
        icache_flush = 1'b1;
        flushed = 1'b1;
      end
      @(posedge gclk); #2;
      icache_flush = 1'b0;
      n++;
    end
    chk("ff_cycles", n, 32'd76);
    chk("ff_data", datai, 32'h0000_00A0);
    chk("ff_fills_left", exp_q.size(), 32'd0);
    lastA = 22'h100;

    // Reset in the middle of a fill.
    ackGap = 2;
    predict(22'h300, h);
    base = nAcked;
    x_en = 1'b1;
    precycle = 22'h300;
    @(posedge gclk); #2;
    x_en = 1'b0;
    for (int i = 0; i < 100 && nAcked < base + 3; i++) begin
      @(posedge gclk); #2;
    end
    chk("mf_beats", nAcked, base + 3);
    grst = 1'b1;
    @(posedge gclk); #2;
    grst = 1'b0;
    forceAck = 1'b1;
    exp_q.delete();
    clearModel();
    chk("mf_req", {31'd0, mem_req}, 32'd0);
    chk("mf_busy", {31'd0, busy}, 32'd1);
    chk("mf_datai", datai, 32'd0);
    sweepCount(n, rs);
    forceAck = 1'b0;
    chk("mf_sweep_len", n, 32'd64);
    chk("mf_no_req", {31'd0, rs}, 32'd0);
    fetch(22'h100, 0);
    fetch(22'h302, 1);
    x_en = 1'b0;

    // Random fetches over a few tags/indexes, with occasional flushes and idles.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        flushIdle();
      end else begin
        ta = int'($urandom_range(0, 3));
        ia = int'($urandom_range(0, 3));
        oa = int'($urandom_range(0, 3));
        fetch(22'(ta * 256 + ia * 4 + oa), int'($urandom_range(0, 2)));
        if ($urandom_range(0, 3) == 0) begin
          x_en = 1'b0;
          @(posedge gclk); #2;
          chk("rand_idle_busy", {31'd0, busy}, 32'd0);
          chk("rand_idle_data", datai, memWord(lastA));
        end
      end
    end
    x_en = 1'b0;
    repeat (2) begin @(posedge gclk); #2; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
